rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 141 ++++++++++++++
 tb/tb_rr_arb_mux.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Registered N-to-1 arbiter/mux with a one-word valid/ready output stage.
// Build option: define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rr_arb_mux #(
    parameter int WIDTH = 64,
    parameter int N     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N-1:0]              in_valid,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    output logic [N-1:0]              in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(N)-1:0]      out_sel,
    input  logic                      out_ready
);

    localparam int SELW = $clog2(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  data_next;
    logic [SELW-1:0]   sel_q;
    logic [SELW-1:0]   sel_next;
    logic              load;
    logic              any_valid;
    logic              take;
    logic [SELW-1:0]   grant;
    logic [N-1:0]      grant_onehot;

    function automatic logic [SELW-1:0] lowest_set(input logic [N-1:0] v);
        logic [SELW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = SELW'(i);
        end
        return idx;
    endfunction

    assign load      = (state == EMPTY) || out_ready;
    assign any_valid = |in_valid;
    assign take      = load && any_valid;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN

    always_comb begin
        grant = lowest_set(in_valid);
    end

`else

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;
    logic [N-1:0]    upper_mask;
    logic [N-1:0]    upper_req;

    // Requests at or above ptr win first; otherwise wrap to the lowest requester.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (SELW'(i) >= ptr);
        end
        upper_req = in_valid & upper_mask;
        if (|upper_req) begin
            grant = lowest_set(upper_req);
        end else begin
            grant = lowest_set(in_valid);
        end
    end

    // Wrap explicitly at N-1 so non-power-of-two N never points past the last channel.
    always_comb begin
        ptr_next = ptr;
        if (take) begin
            if (grant == LAST) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

`endif

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N; i++) begin
            grant_onehot[i] = (grant == SELW'(i));
        end
    end

    // Gated by reset_n so no channel sees an acceptance while the block is held in reset.
    assign in_ready = (take && reset_n) ? grant_onehot : '0;

    always_comb begin
        state_next = state;
        data_next  = data_q;
        sel_next   = sel_q;
        if (load) begin
            if (any_valid) begin
                state_next = FULL;
                data_next  = in_data[grant];
                sel_next   = grant;
            end else begin
                state_next = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            state  <= state_next;
            data_q <= data_next;
            sel_q  <= sel_next;
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N=4 and N=3 instances, WIDTH=8).
// Adapts its expectations when RR_ARB_MUX_FIXED_PRIO_EN is defined.
module tb_rr_arb_mux;

    logic            clk;
    logic            reset_n;
    logic [3:0]      in_valid;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    logic [2:0]      in_valid3;
    logic [2:0][7:0] in_data3;
    logic [2:0]      in_ready3;
    logic            out_valid3;
    logic [7:0]      out_data3;
    logic [1:0]      out_sel3;
    logic            out_ready3;

    int error_count;
    int check_count;
    int hs55_count;

    rr_arb_mux #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready && out_data == 8'h55) hs55_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        in_valid  = '0;
        in_valid3 = '0;
        out_ready = 1'b0;
        out_ready3 = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check_count++;
        if (out_valid !== 1'b0) begin error_count++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        check_count++;
        if (out_data !== 8'h00) begin error_count++; $display("[TB] FAIL reset_out_data: got %0h expected 0", out_data); end
        check_count++;
        if (out_sel !== 2'd0) begin error_count++; $display("[TB] FAIL reset_out_sel: got %0d expected 0", out_sel); end
        check_count++;
        if (in_ready !== 4'b0000) begin error_count++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready); end
        step();
        step();
        check_count++;
        if (out_valid !== 1'b0) begin error_count++; $display("[TB] FAIL reset_held_out_valid: got %0b expected 0", out_valid); end
        reset_n = 1'b1;
        #1;
        check_count++;
        if (in_ready !== 4'b0001) begin error_count++; $display("[TB] FAIL reset_first_ready: got %b expected 0001", in_ready); end
        step();
        check_count++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
            error_count++;
            $display("[TB] FAIL reset_first_grant: got v=%0b sel=%0d data=%0h expected v=1 sel=0 data=a0", out_valid, out_sel, out_data);
        end
    endtask

`ifndef RR_ARB_MUX_FIXED_PRIO_EN

    task automatic test_round_robin();
        logic [7:0] exp_d;
        logic [1:0] exp_s;
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_s = 2'(i % 4);
            exp_d = 8'hA0 + 8'(i % 4);
            #1;
            check_count++;
            if (in_ready !== (4'b0001 << exp_s)) begin error_count++; $display("[TB] FAIL rr_in_ready[%0d]: got %b expected %b", i, in_ready, 4'b0001 << exp_s); end
            step();
            check_count++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== exp_s) begin
                error_count++;
                $display("[TB] FAIL rr_out[%0d]: got v=%0b data=%0h sel=%0d expected v=1 data=%0h sel=%0d", i, out_valid, out_data, out_sel, exp_d, exp_s);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_count++;
            if (in_ready !== 4'b0000) begin error_count++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready); end
            step();
            check_count++;
            if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_sel !== 2'd1) begin
                error_count++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%0b data=%0h sel=%0d expected v=1 data=a1 sel=1", i, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        check_count++;
        if (in_ready !== 4'b0100) begin error_count++; $display("[TB] FAIL bp_release_ready: got %b expected 0100", in_ready); end
        step();
        check_count++;
        if (out_data !== 8'hA2 || out_sel !== 2'd2) begin error_count++; $display("[TB] FAIL bp_next_grant: got data=%0h sel=%0d expected data=a2 sel=2", out_data, out_sel); end
    endtask

    task automatic test_sparse();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        step();
        check_count++;
        if (out_sel !== 2'd2) begin error_count++; $display("[TB] FAIL sparse_setup_sel: got %0d expected 2", out_sel); end
        in_valid = 4'b0010;
        #1;
        check_count++;
        if (in_ready !== 4'b0010) begin error_count++; $display("[TB] FAIL sparse_ready: got %b expected 0010", in_ready); end
        step();
        check_count++;
        if (out_sel !== 2'd1 || out_data !== 8'hA1) begin error_count++; $display("[TB] FAIL sparse_grant: got sel=%0d data=%0h expected sel=1 data=a1", out_sel, out_data); end
        in_valid = 4'b0000;
        #1;
        check_count++;
        if (in_ready !== 4'b0000) begin error_count++; $display("[TB] FAIL idle_ready: got %b expected 0000", in_ready); end
        step();
        check_count++;
        if (out_valid !== 1'b0 || out_data !== 8'hA1 || out_sel !== 2'd1) begin
            error_count++;
            $display("[TB] FAIL idle_drain: got v=%0b data=%0h sel=%0d expected v=0 data=a1 sel=1", out_valid, out_data, out_sel);
        end
        in_valid = 4'b1111;
        #1;
        check_count++;
        if (in_ready !== 4'b0100) begin error_count++; $display("[TB] FAIL sparse_ptr_ready: got %b expected 0100", in_ready); end
        step();
        check_count++;
        if (out_sel !== 2'd2) begin error_count++; $display("[TB] FAIL sparse_ptr_sel: got %0d expected 2", out_sel); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_s;
        do_reset();
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_s = (i % 2 == 0) ? 2'd1 : 2'd3;
            step();
            check_count++;
            if (out_sel !== exp_s) begin error_count++; $display("[TB] FAIL alt_sel[%0d]: got %0d expected %0d", i, out_sel, exp_s); end
        end
    endtask

`else

    task automatic test_fixed_prio();
        do_reset();
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_count++;
            if (in_ready !== 4'b0010) begin error_count++; $display("[TB] FAIL fp_ready[%0d]: got %b expected 0010", i, in_ready); end
            step();
            check_count++;
            if (out_sel !== 2'd1 || out_data !== 8'hA1) begin error_count++; $display("[TB] FAIL fp_sel[%0d]: got sel=%0d data=%0h expected sel=1 data=a1", i, out_sel, out_data); end
        end
    endtask

`endif

    task automatic test_wrap_n3();
        do_reset();
        out_ready3 = 1'b1;
        in_valid3  = 3'b010;
        #1;
        check_count++;
        if (in_ready3 !== 3'b010) begin error_count++; $display("[TB] FAIL n3_ready1: got %b expected 010", in_ready3); end
        step();
        check_count++;
        if (out_sel3 !== 2'd1) begin error_count++; $display("[TB] FAIL n3_sel1: got %0d expected 1", out_sel3); end
        in_valid3 = 3'b100;
        step();
        check_count++;
        if (out_sel3 !== 2'd2 || out_data3 !== 8'hC2) begin error_count++; $display("[TB] FAIL n3_sel2: got sel=%0d data=%0h expected sel=2 data=c2", out_sel3, out_data3); end
        in_valid3 = 3'b111;
        #1;
        check_count++;
        if (in_ready3 !== 3'b001) begin error_count++; $display("[TB] FAIL n3_wrap_ready: got %b expected 001", in_ready3); end
        step();
        check_count++;
        if (out_sel3 !== 2'd0 || out_data3 !== 8'hC0) begin error_count++; $display("[TB] FAIL n3_wrap_sel: got sel=%0d data=%0h expected sel=0 data=c0", out_sel3, out_data3); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_data[0] = 8'h55;
        in_valid   = 4'b0001;
        out_ready  = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        #1;
        check_count++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin error_count++; $display("[TB] FAIL mid_full: got v=%0b data=%0h expected v=1 data=55", out_valid, out_data); end
        #1;
        reset_n = 1'b0;
        #1;
        check_count++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            error_count++;
            $display("[TB] FAIL mid_async_clear: got v=%0b data=%0h sel=%0d expected v=0 data=0 sel=0", out_valid, out_data, out_sel);
        end
        out_ready = 1'b1;
        step();
        check_count++;
        if (out_valid !== 1'b0) begin error_count++; $display("[TB] FAIL mid_held: got %0b expected 0", out_valid); end
        check_count++;
        if (hs55_count !== 0) begin error_count++; $display("[TB] FAIL mid_no_handshake: got %0d expected 0", hs55_count); end
        in_data[0] = 8'hA0;
        in_valid   = 4'b1111;
        reset_n    = 1'b1;
        #1;
        check_count++;
        if (in_ready !== 4'b0001) begin error_count++; $display("[TB] FAIL mid_restart_ready: got %b expected 0001", in_ready); end
        step();
        check_count++;
        if (out_sel !== 2'd0 || out_data !== 8'hA0) begin error_count++; $display("[TB] FAIL mid_restart_grant: got sel=%0d data=%0h expected sel=0 data=a0", out_sel, out_data); end
    endtask

    initial begin
        error_count = 0;
        check_count = 0;
        hs55_count  = 0;
        reset_n     = 1'b0;
        in_valid    = '0;
        out_ready   = 1'b0;
        in_valid3   = '0;
        out_ready3  = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 3; i++) in_data3[i] = 8'hC0 + 8'(i);
        test_reset();
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_alternate();
`else
        test_fixed_prio();
`endif
        test_wrap_n3();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
